// File: rtl/issue_pkg.sv
// issue_pkg: CDB owner encodings and default unit latencies for the issue scheduler
package issue_pkg;
  typedef enum logic [1:0] {
    CDB_INT  = 2'd0,
    CDB_MULT = 2'd1,
    CDB_DIV  = 2'd2,
    CDB_LD   = 2'd3
  } cdb_own_e;
  localparam int MULT_LAT_DEF = 4;
  localparam int DIV_LAT_DEF  = 7;
endpackage

// File: rtl/cdb_resv.sv
// cdb_resv: CDB slot reservation and owner shift register; slot j means the bus is busy j cycles from now
module cdb_resv import issue_pkg::*; #(
  parameter int DEPTH = DIV_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DEPTH:1]        set,
  input  logic [DEPTH:1][1:0]   own_in,
  output logic [DEPTH:0]        res,
  output logic [1:0]            own0
);
  logic [DEPTH:0]      res_q, res_d;
  logic [DEPTH:0][1:0] own_q, own_d;
  // advance every reservation one slot toward the bus, merging new ones at their latency
  always_comb begin
    res_d = '0;
    own_d = '0;
    for (int j = 0; j < DEPTH; j++) begin
      res_d[j] = res_q[j+1] | set[j+1];
      own_d[j] = set[j+1] ? own_in[j+1] : own_q[j+1];
    end
  end
  // reservation state; reset discards everything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q <= '0;
      own_q <= '0;
    end else begin
      res_q <= res_d;
      own_q <= own_d;
    end
  end
  assign res  = res_q;
  assign own0 = own_q[0];
endmodule

// File: rtl/issue_unit.sv
// issue_unit: CDB-conflict-free issue scheduler for int/mult/div/load queues; ISSUE_RR_EN selects int/load round-robin instead of load-first priority
module issue_unit import issue_pkg::*; #(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issueint_ready,
  input  logic       issuemult_ready,
  input  logic       issuediv_ready,
  input  logic       issueld_ready,
  output logic       issueint_done,
  output logic       issuemult_done,
  output logic       issuediv_done,
  output logic       issueld_done,
  output logic [1:0] cdb_sel,
  output logic       cdb_sel_valid
);
  localparam int CW = $clog2(DIV_LAT);
  logic [DIV_LAT:0]      res;
  logic [1:0]            own0;
  logic [DIV_LAT:1]      set;
  logic [DIV_LAT:1][1:0] own_in;
  logic [CW-1:0]         div_cnt_q, div_cnt_d;
  logic                  int_g, mult_g, div_g, ld_g, slot1_free;
  logic                  unused_res;
`ifdef ISSUE_RR_EN
  logic                  rr_q, rr_d;
`endif
  assign slot1_free = !res[1];
  assign unused_res = ^res;
  // grants: each unit issues only if its landing slot is free; int and load share slot 1
  always_comb begin
    div_g  = issuediv_ready && div_cnt_q == '0 && !res[DIV_LAT];
    mult_g = issuemult_ready && !res[MULT_LAT];
`ifdef ISSUE_RR_EN
    ld_g   = issueld_ready && slot1_free && (!issueint_ready || rr_q);
`else
    ld_g   = issueld_ready && slot1_free;
`endif
    int_g  = issueint_ready && slot1_free && !ld_g;
`ifdef ISSUE_RR_EN
    rr_d   = int_g ? 1'b1 : ld_g ? 1'b0 : rr_q;
`endif
    div_cnt_d = div_g ? CW'(DIV_LAT - 1) : div_cnt_q == '0 ? '0 : div_cnt_q - 1'b1;
  end
  // translate grants into reservations at each unit's latency
  always_comb begin
    set = '0;
    own_in = '0;
    set[1] = int_g | ld_g;
    own_in[1] = ld_g ? CDB_LD : CDB_INT;
    set[MULT_LAT] = mult_g;
    own_in[MULT_LAT] = CDB_MULT;
    set[DIV_LAT] = div_g;
    own_in[DIV_LAT] = CDB_DIV;
  end
  // divider occupancy and fairness pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
`ifdef ISSUE_RR_EN
      rr_q <= 1'b0;
`endif
    end else begin
      div_cnt_q <= div_cnt_d;
`ifdef ISSUE_RR_EN
      rr_q <= rr_d;
`endif
    end
  end
  cdb_resv #(.DEPTH(DIV_LAT)) u_resv (
    .clk(clk),
    .reset(reset),
    .set(set),
    .own_in(own_in),
    .res(res),
    .own0(own0)
  );
  assign issueint_done  = int_g & ~reset;
  assign issuemult_done = mult_g & ~reset;
  assign issuediv_done  = div_g & ~reset;
  assign issueld_done   = ld_g & ~reset;
  assign cdb_sel_valid  = res[0] & ~reset;
  assign cdb_sel        = reset ? CDB_INT : own0;
endmodule

// File: tb/tb_issue_unit.sv
// tb_issue_unit: calendar-model check of issue_unit under directed and random ready traffic
module tb_issue_unit;
  import issue_pkg::*;
  localparam int ML = MULT_LAT_DEF;
  localparam int DL = DIV_LAT_DEF;
  logic clk = 1'b0;
  logic reset, ir, mr, dr, lr;
  logic issueint_done, issuemult_done, issuediv_done, issueld_done, cdb_sel_valid;
  logic [1:0] cdb_sel;
  int checks = 0, failures = 0, now = 0, div_ok_at = 0;
  bit ld_turn = 0;
  logic [1:0] cal[int];
  always #5 clk = ~clk;
  issue_unit dut (
    .clk(clk),
    .reset(reset),
    .issueint_ready(ir),
    .issuemult_ready(mr),
    .issuediv_ready(dr),
    .issueld_ready(lr),
    .issueint_done(issueint_done),
    .issuemult_done(issuemult_done),
    .issuediv_done(issuediv_done),
    .issueld_done(issueld_done),
    .cdb_sel(cdb_sel),
    .cdb_sel_valid(cdb_sel_valid)
  );
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, now, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic i, input logic m, input logic d, input logic l);
    logic gi, gm, gd, gl, f1, due;
    reset = r; ir = i; mr = m; dr = d; lr = l;
    @(negedge clk);
    f1 = !cal.exists(now + 1);
`ifdef ISSUE_RR_EN
    gl = !r && l && f1 && (!i || ld_turn);
`else
    gl = !r && l && f1;
`endif
    gi = !r && i && f1 && !gl;
    gm = !r && m && !cal.exists(now + ML);
    gd = !r && d && now >= div_ok_at && !cal.exists(now + DL);
    due = !r && cal.exists(now);
    chk("int_done", issueint_done, gi);
    chk("mult_done", issuemult_done, gm);
    chk("div_done", issuediv_done, gd);
    chk("ld_done", issueld_done, gl);
    chk("cdb_valid", cdb_sel_valid, due);
    if (r) chk("cdb_sel_rst", cdb_sel, 0);
    else if (due) chk("cdb_sel", cdb_sel, cal[now]);
    @(posedge clk);
    if (r) begin
      cal.delete();
      div_ok_at = 0;
      ld_turn = 0;
    end else begin
      if (gi || gl) begin
        cal[now + 1] = gl ? CDB_LD : CDB_INT;
        ld_turn = gi;
      end
      if (gm) cal[now + ML] = CDB_MULT;
      if (gd) begin
        cal[now + DL] = CDB_DIV;
        div_ok_at = now + DL;
      end
      if (cal.exists(now)) cal.delete(now);
    end
    now++;
    #1;
  endtask
  initial begin
    reset = 1; ir = 0; mr = 0; dr = 0; lr = 0;
    repeat (3) cyc(1, 1, 1, 1, 1);
    cyc(0, 1, 1, 1, 1);
    repeat (3) cyc(1, 0, 0, 0, 0);
    repeat (10) cyc(0, 1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0);
    repeat (16) cyc(0, 0, 0, 1, 0);
    repeat (8) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    repeat (4) cyc(0, 1, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    repeat (10) cyc(0, 0, 0, 0, 0);
    repeat (1500) cyc($urandom_range(0, 63) == 0, $urandom_range(0, 9) < 6,
                      $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3,
                      $urandom_range(0, 9) < 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/issue_unit.md
# issue_unit

Issue scheduler for the Tomasulo back end. Sits between the four execution queues (equeueint, equeuemult, equeuediv, load buffer) and their functional units; each cycle it decides which ready queue heads issue, so that no two results ever land on the single CDB in the same cycle. It keeps a CDB slot-reservation shift register, a divider busy counter and an int/load fairness pointer, and tells the CDB mux which unit owns the bus each cycle.

## Interface
Parameters:
- MULT_LAT, 4, multiplier latency in cycles, issue to CDB (pipelined unit)
- DIV_LAT, 7, divider latency in cycles, issue to CDB (non-pipelined unit)
- Constraint: 1 < MULT_LAT < DIV_LAT; int and load latency fixed at 1

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- issueint_ready  in  1  equeueint head valid with both operands
- issuemult_ready  in  1  equeuemult head ready
- issuediv_ready  in  1  equeuediv head ready
- issueld_ready  in  1  load buffer head ready
- issueint_done  out  1  int head issues this cycle (queue pops at next edge)
- issuemult_done  out  1  mult head issues this cycle
- issuediv_done  out  1  div head issues this cycle
- issueld_done  out  1  load head issues this cycle
- cdb_sel  out  2  CDB owner this cycle: 0 int, 1 mult, 2 div, 3 load
- cdb_sel_valid  out  1  a result is due on the CDB this cycle

## Operation
- State: res[0..DIV_LAT] (occupied bits) and own[0..DIV_LAT] (2-bit owner); res[j] means CDB busy j cycles from now.
- Grants, combinational from ready inputs and state:
  - div: issuediv_ready && div_cnt == 0 && !res[DIV_LAT]
  - mult: issuemult_ready && !res[MULT_LAT]
  - int/load: share slot 1; at most one granted, only if !res[1]; arbitration per Configuration.
- div, mult and one of int/load can all issue in the same cycle; their target slots differ by construction.
- Update at each edge: res[j] <= res[j+1] | (grant with latency j+1); own shifts the same way; res[DIV_LAT] <= 0.
- cdb_sel/cdb_sel_valid = own[0]/res[0].
- div_cnt: loads DIV_LAT-1 on div grant, else decrements to 0; next div is accepted DIV_LAT cycles after the previous one.
- Reset: res, own, div_cnt cleared, rr pointer = int. All *_done and cdb_sel_valid are forced 0 while reset is high, and cdb_sel = 0. A reset mid-operation discards all reservations; the functional units flush on the same reset.

## Timing
- done is combinational, same cycle as ready. A queue asserting ready in cycle t with a free slot sees done in t.
- Result of an issue in cycle t appears with cdb_sel_valid in cycle t+L: L=1 int/load, MULT_LAT mult, DIV_LAT div.
- Zero-cycle bubble: back-to-back int issues every cycle with no mult/div traffic.
- A blocked requester keeps ready high. It gets no done until its slot frees. No timeout.

## Configuration
- ISSUE_RR_EN defined: 1-bit round-robin pointer between int and load. On conflict, grant the side the pointer names. Pointer flips to the other side after each int or load grant.
- Undefined: fixed priority, load over int. Pointer logic is absent.

## Structure
- Shared package issue_pkg: CDB owner encodings (CDB_INT=0, CDB_MULT=1, CDB_DIV=2, CDB_LD=3), default latencies.
- One sub-module, cdb_resv: reservation/owner shift register with a parameterized depth. Inputs are a set-vector and owner per latency; outputs are the occupied bits and the slot-0 owner. The arbitration logic stays in issue_unit.

## Test plan
- Reset: hold reset with all ready=1 → all done=0, cdb_sel_valid=0. First cycle after release: divdone, multdone and one of int/ld done =1.
- Int only, ready for 10 cycles → issueint_done=1 each cycle; cdb_sel=0 valid from 1 cycle after first issue, continuously.
- Mult at t, int ready at t+3 → int blocked at t+3 (slot t+4 owned by mult, cdb_sel=1); int done at t+4, on CDB at t+5.
- Two divs back-to-back → second issuediv_done exactly 7 cycles after first; cdb_sel=2 at t+7 and t+14.
- Int and load both ready for 4 cycles: with ISSUE_RR_EN → grants alternate int, ld, int, ld. Without → ld 4 times, int 0.
- Reset asserted 2 cycles after a div issue → cdb_sel_valid never asserts for that div; div accepted immediately after reset.
